bcd_serial_adder: RTL

- Parametrised, digit-serial BCD adder/subtractor for multi-digit packed-BCD operands; one BCD digit per clock, LSB digit first.
- Carry/borrow is held in a register between digit steps.
- Sits between the switch/counter logic and the BCD-to-FND display path; o_sum feeds the digit decoders directly.
- Generalises the bit-level full adder to N BCD digits, with add/subtract mode, a start/done handshake and invalid-digit detection.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_adder.sv | 30 +++
 rtl/bcd_serial_adder.sv | 116 +++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder/subtractor.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int             BCD_W     = 4;
  localparam logic [3:0]     BCD_MAX   = 4'd9;
  localparam logic [4:0]     BCD_RADIX = 5'd10;

  // Number of bits needed to address DIGITS digit slots, never less than one.
  function automatic int idx_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// One-digit BCD add/subtract cell: optional nine's complement of b, then >9 correction.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [BCD_W-1:0] digit,
  output logic             cout
);

  logic [BCD_W-1:0] b_eff;
  logic [BCD_W:0]   raw_sum;
  logic [BCD_W:0]   corrected;

  always_comb begin
    b_eff     = sub ? (BCD_MAX - b) : b;
    raw_sum   = {1'b0, a} + {1'b0, b_eff} + {{BCD_W{1'b0}}, cin};
    corrected = raw_sum - BCD_RADIX;
    if (raw_sum > {1'b0, BCD_MAX}) begin
      digit = corrected[BCD_W-1:0];
      cout  = 1'b1;
    end else begin
      digit = raw_sum[BCD_W-1:0];
      cout  = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock LSB first,
// with start/done handshake and invalid-digit detection.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_sub,
  input  logic [4*DIGITS-1:0]   i_a,
  input  logic [4*DIGITS-1:0]   i_b,
  output logic [4*DIGITS-1:0]   o_sum,
  output logic                  o_carry,
  output logic                  o_invalid,
  output logic                  o_ready,
  output logic                  o_done
);

  localparam int IDX_W = idx_width(DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t                          state;
  logic [DIGITS-1:0][BCD_W-1:0]    a_q;
  logic [DIGITS-1:0][BCD_W-1:0]    b_q;
  logic [DIGITS-1:0][BCD_W-1:0]    res_q;
  logic [DIGITS-1:0][BCD_W-1:0]    res_next;
  logic                            sub_q;
  logic                            carry_q;
  logic [IDX_W-1:0]                idx_q;
  logic [BCD_W-1:0]                digit;
  logic                            cout;

  function automatic logic has_invalid(input logic [4*DIGITS-1:0] a,
                                       input logic [4*DIGITS-1:0] b);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[i*BCD_W +: BCD_W] > BCD_MAX) bad = 1'b1;
      if (b[i*BCD_W +: BCD_W] > BCD_MAX) bad = 1'b1;
    end
    return bad;
  endfunction

  bcd_digit_adder u_digit (
    .a     (a_q[idx_q]),
    .b     (b_q[idx_q]),
    .cin   (carry_q),
    .sub   (sub_q),
    .digit (digit),
    .cout  (cout)
  );

  // Full result including the digit being produced this cycle, so the
  // final edge can publish o_sum without an extra cycle.
  always_comb begin
    res_next        = res_q;
    res_next[idx_q] = digit;
  end

  assign o_ready = (state == ST_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      sub_q     <= 1'b0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      o_sum     <= '0;
      o_carry   <= 1'b0;
      o_invalid <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            a_q       <= i_a;
            b_q       <= i_b;
            sub_q     <= i_sub;
            carry_q   <= i_sub;
            idx_q     <= '0;
            res_q     <= '0;
            o_sum     <= '0;
            o_carry   <= 1'b0;
            o_invalid <= has_invalid(i_a, i_b);
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_q   <= res_next;
          carry_q <= cout;
          if (idx_q == LAST_IDX) begin
            o_sum   <= o_invalid ? '0 : res_next;
            o_carry <= o_invalid ? 1'b0 : cout;
            o_done  <= 1'b1;
            state   <= ST_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
